// File: rtl/traffic_light_monitor_pkg.sv
// ============================================================================
// Module      : traffic_light_monitor_pkg
// Description : Shared aspect/state encodings, fault codes and decode helpers
//               for the traffic light monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_light_monitor_pkg;

    typedef enum logic [2:0] {
        DARK  = 3'd0,
        RED   = 3'd1,
        YEL   = 3'd2,
        GRN   = 3'd3,
        MULTI = 3'd4
    } aspect_e;

    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_RUN   = 2'd1,
        MON_FAULT = 2'd2
    } mon_state_e;

    localparam logic [2:0] FLT_NONE      = 3'd0;
    localparam logic [2:0] FLT_CONFLICT  = 3'd1;
    localparam logic [2:0] FLT_MULTI     = 3'd2;
    localparam logic [2:0] FLT_SEQUENCE  = 3'd3;
    localparam logic [2:0] FLT_SHORT_YEL = 3'd4;
    localparam logic [2:0] FLT_DARK      = 3'd5;
    localparam logic [2:0] FLT_WATCHDOG  = 3'd6;

    function automatic aspect_e decode_aspect(input logic red, input logic yel, input logic grn);
        case ({red, yel, grn})
            3'b000:  return DARK;
            3'b100:  return RED;
            3'b010:  return YEL;
            3'b001:  return GRN;
            default: return MULTI;
        endcase
    endfunction

    function automatic logic is_single(input aspect_e asp);
        return (asp == RED) || (asp == YEL) || (asp == GRN);
    endfunction

    // Only the forward R->G->Y->R rotation is a legal aspect change.
    function automatic logic legal_step(input aspect_e from_asp, input aspect_e to_asp);
        return ((from_asp == RED) && (to_asp == GRN)) ||
               ((from_asp == GRN) && (to_asp == YEL)) ||
               ((from_asp == YEL) && (to_asp == RED));
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_light_monitor_head.sv
// ============================================================================
// Module      : tl_head_tracker
// Description : Per-head aspect decoder with dwell/dark counters and
//               sequence, short-yellow, dark and watchdog event flags.
//               Optional macro TRAFFIC_LIGHT_MONITOR_STATS_EN adds r2g_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_head_tracker
    import traffic_light_monitor_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int MIN_YELLOW = 250,
    parameter int MAX_DWELL  = 3000,
    parameter int DARK_TOL   = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    clr_i,
    input  logic    hold_i,
    input  logic    red_i,
    input  logic    yellow_i,
    input  logic    green_i,
    output aspect_e aspect_o,
    output logic    seq_err_o,
    output logic    short_yel_o,
    output logic    dark_err_o,
    output logic    wd_err_o
`ifdef TRAFFIC_LIGHT_MONITOR_STATS_EN
    ,
    output logic    r2g_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_YEL_C    = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_DWELL_C  = CNT_W'(MAX_DWELL);
    localparam logic [CNT_W-1:0] DARK_TOL_C   = CNT_W'(DARK_TOL);

    aspect_e          last_q, last_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] dark_q, dark_d;
    logic             first_yel_q, first_yel_d;

    aspect_e          w_asp;
    logic             w_change;
    logic             w_y2r;

    always_comb begin
        w_asp       = decode_aspect(red_i, yellow_i, green_i);
        w_change    = is_single(w_asp) && (w_asp != last_q);
        w_y2r       = (last_q == YEL) && (w_asp == RED);
        last_d      = w_change ? w_asp : last_q;
        first_yel_d = w_y2r ? 1'b0 : first_yel_q;

        // Dark and multi-lamp cycles keep counting toward the previous aspect.
        if (w_change) begin
            dwell_d = CNT_ONE;
        end else if (dwell_q == CNT_MAX) begin
            dwell_d = dwell_q;
        end else begin
            dwell_d = dwell_q + CNT_ONE;
        end

        if (w_asp != DARK) begin
            dark_d = '0;
        end else if (dark_q == CNT_MAX) begin
            dark_d = dark_q;
        end else begin
            dark_d = dark_q + CNT_ONE;
        end
    end

    assign aspect_o    = w_asp;
    assign seq_err_o   = w_change && (last_q != DARK) && !legal_step(last_q, w_asp);
    assign short_yel_o = w_y2r && !first_yel_q && (dwell_q < MIN_YEL_C);
    assign dark_err_o  = dark_d > DARK_TOL_C;
    assign wd_err_o    = dwell_d > MAX_DWELL_C;
`ifdef TRAFFIC_LIGHT_MONITOR_STATS_EN
    assign r2g_o       = (last_q == RED) && (w_asp == GRN);
`endif

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            last_q      <= DARK;
            dwell_q     <= '0;
            dark_q      <= '0;
            first_yel_q <= 1'b1;
        end else if (!hold_i) begin
            last_q      <= last_d;
            dwell_q     <= dwell_d;
            dark_q      <= dark_d;
            first_yel_q <= first_yel_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/traffic_light_monitor.sv
// ============================================================================
// Module      : traffic_light_monitor
// Description : Passive two-head lamp monitor; latches the first fault code
//               and requests fail-safe flash. Optional macro
//               TRAFFIC_LIGHT_MONITOR_STATS_EN adds the cycle_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_light_monitor
    import traffic_light_monitor_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int MIN_YELLOW = 250,
    parameter int MAX_DWELL  = 3000,
    parameter int DARK_TOL   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        red1,
    input  logic        yellow1,
    input  logic        green1,
    input  logic        red2,
    input  logic        yellow2,
    input  logic        green2,
    input  logic        fault_clr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic        flash_req,
    output logic        monitoring
`ifdef TRAFFIC_LIGHT_MONITOR_STATS_EN
    ,
    output logic [15:0] cycle_count
`endif
);

    logic [2:0] lamp1_q, lamp2_q;
    mon_state_e state_q, state_d;
    logic [2:0] code_q, code_d;

    aspect_e    w_asp1, w_asp2;
    logic       w_seq1, w_seq2, w_short1, w_short2;
    logic       w_dark1, w_dark2, w_wd1, w_wd2;
    logic       w_hold, w_clr;
    logic [2:0] w_flt;
`ifdef TRAFFIC_LIGHT_MONITOR_STATS_EN
    logic       w_r2g1, w_r2g2;
    logic [15:0] cycle_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            lamp1_q <= '0;
            lamp2_q <= '0;
        end else begin
            lamp1_q <= {red1, yellow1, green1};
            lamp2_q <= {red2, yellow2, green2};
        end
    end

    assign w_hold = (state_q == MON_FAULT);
    assign w_clr  = w_hold && fault_clr;

    tl_head_tracker #(
        .CNT_W      (CNT_W),
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_DWELL  (MAX_DWELL),
        .DARK_TOL   (DARK_TOL)
    ) u_head1 (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (w_clr),
        .hold_i      (w_hold),
        .red_i       (lamp1_q[2]),
        .yellow_i    (lamp1_q[1]),
        .green_i     (lamp1_q[0]),
        .aspect_o    (w_asp1),
        .seq_err_o   (w_seq1),
        .short_yel_o (w_short1),
        .dark_err_o  (w_dark1),
        .wd_err_o    (w_wd1)
`ifdef TRAFFIC_LIGHT_MONITOR_STATS_EN
        ,
        .r2g_o       (w_r2g1)
`endif
    );

    tl_head_tracker #(
        .CNT_W      (CNT_W),
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_DWELL  (MAX_DWELL),
        .DARK_TOL   (DARK_TOL)
    ) u_head2 (
        .clk         (clk),
        .reset       (reset),
        .clr_i       (w_clr),
        .hold_i      (w_hold),
        .red_i       (lamp2_q[2]),
        .yellow_i    (lamp2_q[1]),
        .green_i     (lamp2_q[0]),
        .aspect_o    (w_asp2),
        .seq_err_o   (w_seq2),
        .short_yel_o (w_short2),
        .dark_err_o  (w_dark2),
        .wd_err_o    (w_wd2)
`ifdef TRAFFIC_LIGHT_MONITOR_STATS_EN
        ,
        .r2g_o       (w_r2g2)
`endif
    );

    always_comb begin
        w_flt   = FLT_NONE;
        state_d = state_q;
        code_d  = code_q;

        // Lowest code wins when several faults appear in the same cycle.
        if (((w_asp1 == GRN) && (w_asp2 != RED)) || ((w_asp2 == GRN) && (w_asp1 != RED))) begin
            w_flt = FLT_CONFLICT;
        end else if ((w_asp1 == MULTI) || (w_asp2 == MULTI)) begin
            w_flt = FLT_MULTI;
        end else if (w_seq1 || w_seq2) begin
            w_flt = FLT_SEQUENCE;
        end else if (w_short1 || w_short2) begin
            w_flt = FLT_SHORT_YEL;
        end else if (w_dark1 || w_dark2) begin
            w_flt = FLT_DARK;
        end else if (w_wd1 || w_wd2) begin
            w_flt = FLT_WATCHDOG;
        end

        case (state_q)
            MON_IDLE: begin
                if (is_single(w_asp1) && is_single(w_asp2)) begin
                    state_d = MON_RUN;
                end
            end
            MON_RUN: begin
                if (w_flt != FLT_NONE) begin
                    state_d = MON_FAULT;
                    code_d  = w_flt;
                end
            end
            MON_FAULT: begin
                if (fault_clr) begin
                    state_d = MON_IDLE;
                    code_d  = FLT_NONE;
                end
            end
            default: begin
                state_d = MON_IDLE;
                code_d  = FLT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MON_IDLE;
            code_q  <= FLT_NONE;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    assign fault      = (state_q == MON_FAULT);
    assign fault_code = code_q;
    assign flash_req  = fault;
    assign monitoring = (state_q == MON_RUN);

`ifdef TRAFFIC_LIGHT_MONITOR_STATS_EN
    // Completed head-1 cycles survive fault_clr; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
        end else if ((state_q == MON_RUN) && w_r2g1) begin
            cycle_cnt_q <= cycle_cnt_q + 16'd1;
        end
    end

    assign cycle_count = cycle_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Randomized and directed bench for traffic_light_monitor,
//               checked against a timestamp-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_light_monitor;

    localparam int MIN_YELLOW = 250;
    localparam int MAX_DWELL  = 3000;
    localparam int DARK_TOL   = 2;
    localparam int CNT_MAX    = 4095;

    logic        clk = 1'b0;
    logic        reset, red1, yellow1, green1, red2, yellow2, green2, fault_clr;
    logic        fault, flash_req, monitoring;
    logic [2:0]  fault_code;
`ifdef TRAFFIC_LIGHT_MONITOR_STATS_EN
    logic [15:0] cycle_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .CNT_W      (12),
        .MIN_YELLOW (MIN_YELLOW),
        .MAX_DWELL  (MAX_DWELL),
        .DARK_TOL   (DARK_TOL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .red1        (red1),
        .yellow1     (yellow1),
        .green1      (green1),
        .red2        (red2),
        .yellow2     (yellow2),
        .green2      (green2),
        .fault_clr   (fault_clr),
        .fault       (fault),
        .fault_code  (fault_code),
        .flash_req   (flash_req),
        .monitoring  (monitoring)
`ifdef TRAFFIC_LIGHT_MONITOR_STATS_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model (aspects as characters, time as edge index)
    bit  m_run, m_flt;
    int  m_code, m_cnt, t;
    byte m_reg[2];
    byte m_last[2];
    int  m_tchg[2];
    int  m_tdark[2];
    bit  m_indark[2];
    bit  m_fy[2];

    function automatic byte asp_of(input bit [2:0] l);
        case (l)
            3'b000:  return "D";
            3'b100:  return "R";
            3'b010:  return "Y";
            3'b001:  return "G";
            default: return "M";
        endcase
    endfunction

    function automatic bit [2:0] lamp_of(input byte a);
        case (a)
            "R":     return 3'b100;
            "Y":     return 3'b010;
            "G":     return 3'b001;
            "M":     return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit legal(input byte f, input byte n);
        return (f == "R" && n == "G") || (f == "G" && n == "Y") || (f == "Y" && n == "R");
    endfunction

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    function automatic bit single(input byte a);
        return (a == "R") || (a == "Y") || (a == "G");
    endfunction

    task automatic clear_heads(input int tstart);
        for (int h = 0; h < 2; h++) begin
            m_last[h]   = 0;
            m_tchg[h]   = tstart;
            m_indark[h] = 0;
            m_fy[h]     = 1;
        end
    endtask

    task automatic model_edge(input bit rst, input bit clr, input bit [5:0] lamps);
        byte a[2];
        bit  seq[2], shrt[2], dk[2], wd[2];
        int  code;
        t++;
        if (rst) begin
            m_run = 0; m_flt = 0; m_code = 0; m_cnt = 0;
            clear_heads(t + 1);
            m_reg[0] = "D"; m_reg[1] = "D";
            return;
        end
        a = m_reg;
        for (int h = 0; h < 2; h++) begin
            bit chg;
            int dq, dd, drun;
            chg = single(a[h]) && (a[h] != m_last[h]);
            dq  = sat(t - m_tchg[h]);
            dd  = chg ? 1 : sat(t - m_tchg[h] + 1);
            if (a[h] == "D") begin
                if (!m_indark[h]) begin
                    m_indark[h] = 1;
                    m_tdark[h]  = t;
                end
                drun = t - m_tdark[h] + 1;
            end else begin
                m_indark[h] = 0;
                drun = 0;
            end
            seq[h]  = chg && (m_last[h] != 0) && !legal(m_last[h], a[h]);
            shrt[h] = (m_last[h] == "Y") && (a[h] == "R") && !m_fy[h] && (dq < MIN_YELLOW);
            dk[h]   = drun > DARK_TOL;
            wd[h]   = dd > MAX_DWELL;
            if (m_last[h] == "Y" && a[h] == "R") m_fy[h] = 0;
            if (h == 0 && m_run && m_last[h] == "R" && a[h] == "G") m_cnt = (m_cnt + 1) & 16'hffff;
            if (chg) begin
                m_last[h] = a[h];
                m_tchg[h] = t;
            end
        end
        code = 0;
        if ((a[0] == "G" && a[1] != "R") || (a[1] == "G" && a[0] != "R")) code = 1;
        else if (a[0] == "M" || a[1] == "M") code = 2;
        else if (seq[0] || seq[1])           code = 3;
        else if (shrt[0] || shrt[1])         code = 4;
        else if (dk[0] || dk[1])             code = 5;
        else if (wd[0] || wd[1])             code = 6;
        if (m_flt) begin
            if (clr) begin
                m_flt = 0; m_code = 0;
                clear_heads(t + 1);
            end
        end else if (m_run) begin
            if (code != 0) begin
                m_flt = 1; m_run = 0; m_code = code;
            end
        end else if (single(a[0]) && single(a[1])) begin
            m_run = 1;
        end
        m_reg[0] = asp_of(lamps[5:3]);
        m_reg[1] = asp_of(lamps[2:0]);
    endtask

    // ---------------- stimulus helpers
    task automatic tick(input bit rst, input bit clr, input bit [5:0] l);
        reset = rst;
        fault_clr = clr;
        {red1, yellow1, green1, red2, yellow2, green2} = l;
        @(posedge clk);
        model_edge(rst, clr, l);
        @(negedge clk);
        check_eq("fault", fault, m_flt);
        check_eq("fault_code", fault_code, m_code);
        check_eq("flash_req", flash_req, m_flt);
        check_eq("monitoring", monitoring, m_run);
`ifdef TRAFFIC_LIGHT_MONITOR_STATS_EN
        check_eq("cycle_count", cycle_count, m_cnt);
`endif
    endtask

    task automatic hold(input byte a1, input byte a2, input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, {lamp_of(a1), lamp_of(a2)});
    endtask

    task automatic pulse_clr(input byte a1, input byte a2);
        tick(1'b0, 1'b1, {lamp_of(a1), lamp_of(a2)});
    endtask

    task automatic legal_cycle(input int yel);
        hold("R", "Y", yel);
        hold("G", "R", 2500);
        hold("Y", "R", yel);
        hold("R", "G", 2250);
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    byte ph_a1[4] = '{"R", "G", "Y", "R"};
    byte ph_a2[4] = '{"Y", "R", "R", "G"};

    initial begin
        int ph, k, n;
        reset = 1'b1; fault_clr = 1'b0;
        {red1, yellow1, green1, red2, yellow2, green2} = '0;
        t = 0;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 6'b0);
        check_eq("reset_fault", fault, 0);
        check_eq("reset_code", fault_code, 0);
        check_eq("reset_mon", monitoring, 0);

        // legal rotation
        hold("Y", "Y", 2);
        check_eq("mon_second_cycle", monitoring, 1);
        hold("Y", "Y", 1);
        legal_cycle(250);
        legal_cycle(250);
        check_eq("legal_no_fault", fault, 0);

        // short yellow, then exact minimum yellow
        hold("R", "Y", 250); hold("G", "R", 100); hold("Y", "R", 249); hold("R", "G", 3);
        check_eq("short_yel_code", fault_code, 4);
        pulse_clr("R", "G");
        check_eq("clr_fault", fault, 0);
        check_eq("clr_idle", monitoring, 0);
        hold("R", "Y", 250); hold("G", "R", 100); hold("Y", "R", 250); hold("R", "G", 100);
        hold("R", "Y", 250); hold("G", "R", 100); hold("Y", "R", 250); hold("R", "G", 5);
        check_eq("min_yel_pass", fault, 0);

        // conflict, outputs hold afterwards
        hold("G", "Y", 1); hold("R", "G", 3);
        check_eq("conflict_code", fault_code, 1);
        check_eq("conflict_flash", flash_req, 1);
        pulse_clr("R", "G");
        hold("R", "G", 2);
        check_eq("rearm_mon", monitoring, 1);

        // multi lamp on head 2 with head 1 red
        hold("R", "M", 1); hold("R", "G", 3);
        check_eq("multi_code", fault_code, 2);
        pulse_clr("R", "G");
        hold("R", "G", 3);

        // dark tolerance then dark fault
        hold("R", "D", 2); hold("R", "G", 3);
        check_eq("dark_tol_pass", fault, 0);
        hold("R", "D", 3); hold("R", "G", 2);
        check_eq("dark_code", fault_code, 5);

        // watchdog
        pulse_clr("G", "R");
        hold("G", "R", 3001); hold("G", "R", 2);
        check_eq("watchdog_code", fault_code, 6);

        // reset and fault_clr on the same edge
        tick(1'b1, 1'b1, {lamp_of("G"), lamp_of("R")});
        check_eq("rst_clr_fault", fault, 0);
        check_eq("rst_clr_code", fault_code, 0);
        check_eq("rst_clr_mon", monitoring, 0);

        // conflict and dark in the same cycle
        hold("R", "G", 3); hold("R", "D", 2); hold("G", "D", 1); hold("R", "G", 3);
        check_eq("conflict_over_dark", fault_code, 1);
        pulse_clr("R", "G");

        // randomized walk around the legal rotation with glitches
        ph = 0;
        for (int it = 0; it < 60; it++) begin
            if (m_flt && $urandom_range(0, 1) == 1) pulse_clr(ph_a1[ph], ph_a2[ph]);
            k = $urandom_range(0, 9);
            if (k <= 5) begin
                n = (ph == 0 || ph == 2) ? $urandom_range(MIN_YELLOW - 3, MIN_YELLOW + 3)
                                         : $urandom_range(5, 200);
                hold(ph_a1[ph], ph_a2[ph], n);
                ph = (ph + 1) % 4;
            end else if (k == 6) begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 6'($urandom));
            end else if (k == 7) begin
                n = $urandom_range(1, 4);
                if ($urandom_range(0, 1) == 1) hold("D", ph_a2[ph], n);
                else                           hold(ph_a1[ph], "D", n);
            end else if (k == 8) begin
                pulse_clr(ph_a1[ph], ph_a2[ph]);
            end else begin
                tick(1'b1, $urandom_range(0, 1) == 1, {lamp_of(ph_a1[ph]), lamp_of(ph_a2[ph])});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive observer on the six lamp lines of a two-head traffic controller (red/yellow/green per head).
- Decodes each head's aspect, checks conflicts, lamp encoding, aspect sequence and dwell timing.
- Latches the first fault with a code and raises a flash request for the cabinet fail-safe logic.
- Never drives the lamps; it sits beside the controller at the lamp-driver boundary.

Parameters:
- CNT_W, 12, width of the per-head dwell counters; counters saturate at 2^CNT_W-1.
- MIN_YELLOW, 250, minimum cycles a head must show yellow before it goes red.
- MAX_DWELL, 3000, watchdog limit in cycles for any single aspect; must be < 2^CNT_W.
- DARK_TOL, 2, maximum consecutive dark (no-lamp) sampled cycles tolerated per head.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- red1 yellow1 green1  in  1 each  head-1 lamp lines.
- red2 yellow2 green2  in  1 each  head-2 lamp lines.
- fault_clr  in  1  single-cycle pulse; clears a latched fault.
- fault  out  1  latched fault flag.
- fault_code  out  3  first-fault code (0 means none).
- flash_req  out  1  equals fault; requests all-red flash.
- monitoring  out  1  high in MON_RUN.

Behaviour:
- Reset values: fault=0, fault_code=0, flash_req=0, monitoring=0, state=MON_IDLE, dwell counters=0, first_yel flags=1.
- Sampling: lamp inputs are registered on every edge. The checks operate on registered values. A bad pattern present at edge E gives fault=1 after edge E+1 (2-cycle latency).
- Head decode, per registered head:
  - Exactly one lamp on gives RED, YEL or GRN.
  - No lamp on gives DARK.
  - More than one lamp on gives MULTI.
- States:
  - MON_IDLE: monitoring=0 and no checks run. Go to MON_RUN when both heads decode to a single lamp. Both-yellow is legal here.
  - MON_RUN: all checks active.
  - MON_FAULT: outputs frozen.
- MON_FAULT exits to MON_IDLE on fault_clr. Exit clears the fault outputs and counters and sets first_yel=1. fault_clr is ignored outside MON_FAULT. reset has priority over fault_clr.
- Fault codes, checked in MON_RUN. If several are detected in the same cycle, the lowest code wins:
  - 1 CONFLICT: either head GRN while the other head is not RED.
  - 2 MULTI: either head decodes MULTI.
  - 3 SEQUENCE: a non-dark aspect change other than R->G, G->Y or Y->R. Compare against the last non-dark aspect.
  - 4 SHORT_YEL: Y->R with yellow dwell < MIN_YELLOW. Exempt while first_yel=1. first_yel clears on the head's first Y->R.
  - 5 DARK: DARK for DARK_TOL+1 consecutive sampled cycles.
  - 6 WATCHDOG: dwell > MAX_DWELL.
- Any detected fault moves the block to MON_FAULT. fault_code holds the first code until cleared.
- Dwell counter per head:
  - Set to 1 on a non-dark aspect change.
  - Otherwise increments, with DARK cycles counting toward the preceding aspect.
  - Saturates and never wraps.
- A dwell of exactly MIN_YELLOW passes. A dwell of exactly MAX_DWELL passes.
- Short DARK gaps (≤ DARK_TOL cycles) are tolerated and produce no sequence event.

Optional Feature:
- Macro TRAFFIC_LIGHT_MONITOR_STATS_EN.
- When defined:
  - Extra output cycle_count (16 bits, reset 0).
  - It increments on each head-1 R->G seen in MON_RUN, wraps at 16 bits, and is not cleared by fault_clr.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package traffic_light_monitor_pkg holds:
  - The aspect encoding: DARK, RED, YEL, GRN, MULTI.
  - The monitor state encoding: MON_IDLE, MON_RUN, MON_FAULT.
  - The fault code constants FLT_NONE..FLT_WATCHDOG.
- Sub-module tl_head_tracker, instantiated twice. It takes a registered lamp triple and provides:
  - aspect, last non-dark aspect, dwell counter, dark-run counter, first_yel flag.
  - Per-cycle event flags: seq_err, short_yel, dark_err, wd_err.
- The top level performs the cross-head conflict check, priority encoding and the state machine.

Test Plan:
- Legal cycle: after reset, drive Y/Y, then R/Y 250, G/R 2500, Y/R 250, R/G 2250, repeated twice -> fault stays 0 and monitoring=1 from the second sampled cycle.
- Conflict: in MON_RUN drive green1=1 with yellow2=1 for one cycle -> fault=1 and fault_code=1 two edges later; outputs hold while the lamps return to legal.
- Multi-lamp: drive head2 yellow2=1 and green2=1 together for one cycle -> fault_code=2 (no conflict, since head1 is RED).
- Short yellow: in the second cycle, head1 shows Y for 249 cycles then R -> fault_code=4. Repeat with 250 cycles -> no fault.
- Dark and watchdog: head2 dark for 2 cycles -> no fault; dark for 3 cycles -> code 5. Separately, hold G/R for 3001 cycles -> code 6.
- Clear and simultaneous events: pulse fault_clr in MON_FAULT -> fault=0 and state MON_IDLE, then re-arm on a legal pattern. Assert reset and fault_clr on the same edge -> reset values. A conflict and a dark fault in the same cycle -> code 1.
